// File: rtl/t05_header_serializer.sv
// Serializes codebook entries (index, length, packed path) into a byte stream
// for the SPI writer, then closes the header with a 0x00 0x00 terminator.
module t05_header_serializer (
  input  logic         clk,
  input  logic         rst,
  input  logic         char_found,
  input  logic [7:0]   char_index,
  input  logic [127:0] char_path,
  input  logic         cb_finished,
  input  logic         spi_ready,
  output logic [7:0]   byte_out,
  output logic         byte_valid,
  output logic         write_finish,
  output logic         header_done,
  output logic         busy
);
  typedef enum logic [2:0] {IDLE, IDX, LEN, PATH, FIN, TERM0, TERM1, HALT} state_t;

  state_t       state;
  logic [127:0] sr;
  logic [6:0]   len_q;
  logic [4:0]   cnt;
  logic         fin_flag;

  logic [6:0]   len_d;
  logic [7:0]   shamt;
  logic [7:0]   len_pad;
  logic [127:0] sr_load;
  logic         xfer;

  // Position of the control bit; 0 means the path carries no moves.
  always_comb begin
    len_d = '0;
    for (int i = 1; i < 128; i++)
      if (char_path[i]) len_d = 7'(i);
  end

  assign shamt   = 8'd128 - {1'b0, len_d};
  assign sr_load = char_path << shamt;
  assign len_pad = {1'b0, len_d} + 8'd7;
  assign xfer    = byte_valid & spi_ready;
  assign busy    = (state != IDLE) && (state != HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      sr           <= '0;
      len_q        <= '0;
      cnt          <= '0;
      fin_flag     <= 1'b0;
      byte_out     <= '0;
      byte_valid   <= 1'b0;
      write_finish <= 1'b0;
      header_done  <= 1'b0;
    end else begin
      fin_flag <= fin_flag | cb_finished;
      case (state)
        IDLE: begin
          if (char_found) begin
            len_q <= len_d;
            sr    <= sr_load;
            cnt   <= 5'(len_pad >> 3);
            if (len_d == '0) begin
              write_finish <= 1'b1;
              state        <= FIN;
            end else begin
              byte_out   <= char_index;
              byte_valid <= 1'b1;
              state      <= IDX;
            end
          end else if (fin_flag) begin
            byte_out   <= 8'h00;
            byte_valid <= 1'b1;
            state      <= TERM0;
          end
        end
        IDX: if (xfer) begin
          byte_out <= {1'b0, len_q};
          state    <= LEN;
        end
        LEN: if (xfer) begin
          byte_out <= sr[127:120];
          state    <= PATH;
        end
        PATH: if (xfer) begin
          sr  <= sr << 8;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            byte_out     <= 8'h00;
            byte_valid   <= 1'b0;
            write_finish <= 1'b1;
            state        <= FIN;
          end else begin
            byte_out <= sr[119:112];
          end
        end
        FIN: begin
          write_finish <= 1'b0;
          state        <= IDLE;
        end
        TERM0: if (xfer) state <= TERM1;
        TERM1: if (xfer) begin
          byte_valid  <= 1'b0;
          header_done <= 1'b1;
          state       <= HALT;
        end
        HALT: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_t05_header_serializer.sv
// Directed + randomized bench for t05_header_serializer with a byte-list model.
module tb_t05_header_serializer;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         char_found = 1'b0;
  logic [7:0]   char_index = '0;
  logic [127:0] char_path = '0;
  logic         cb_finished = 1'b0;
  logic         spi_ready = 1'b0;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         write_finish;
  logic         header_done;
  logic         busy;

  t05_header_serializer dut (
    .clk(clk), .rst(rst), .char_found(char_found), .char_index(char_index),
    .char_path(char_path), .cb_finished(cb_finished), .spi_ready(spi_ready),
    .byte_out(byte_out), .byte_valid(byte_valid), .write_finish(write_finish),
    .header_done(header_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  bit rdy_mode = 1'b0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int   wf_cnt = 0;
  int   wf_cyc = 0;
  int   stab_err = 0;
  bit   stall_prev = 1'b0;
  logic [7:0] stall_byte = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    spi_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Observe transfers, finish pulses and stall stability mid-cycle.
  always @(negedge clk) begin
    if (stall_prev && !(byte_valid && byte_out == stall_byte)) stab_err++;
    stall_prev = rst && byte_valid && !spi_ready;
    stall_byte = byte_out;
    if (byte_valid && spi_ready) got_q.push_back(byte_out);
    if (write_finish) begin
      wf_cnt++;
      wf_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Expected stream: index, length, then moves packed MSB-first into bytes.
  task automatic build_exp(input logic [7:0] idx, input logic [127:0] p);
    int top = 0;
    bit mv[$];
    logic [7:0] b;
    exp_q.delete();
    for (int i = 1; i < 128; i++) if (p[i]) top = i;
    if (top == 0) return;
    exp_q.push_back(idx);
    exp_q.push_back(8'(top));
    for (int i = top - 1; i >= 0; i--) mv.push_back(p[i]);
    while (mv.size() % 8 != 0) mv.push_back(1'b0);
    for (int k = 0; k < mv.size(); k += 8) begin
      b = '0;
      for (int j = 0; j < 8; j++) b = {b[6:0], mv[k + j]};
      exp_q.push_back(b);
    end
  endtask

  task automatic cmp_bytes(input string tag, input int base);
    chk({tag, " nbytes"}, 128'(got_q.size() - base), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), 128'(got_q[base + i]), 128'(exp_q[i]));
  endtask

  task automatic send_entry(input string tag, input logic [7:0] idx, input logic [127:0] p);
    int base = got_q.size();
    int wf0 = wf_cnt;
    int cap;
    int n = 0;
    build_exp(idx, p);
    char_index = idx; char_path = p; char_found = 1'b1;
    @(posedge clk); #1;
    char_found = 1'b0;
    cap = cyc;
    if (exp_q.size() != 0) begin
      chk({tag, " first byte"}, 128'(byte_out), 128'(idx));
      chk({tag, " valid"}, 128'(byte_valid), 128'(1));
      chk({tag, " busy"}, 128'(busy), 128'(1));
    end
    while (wf_cnt == wf0 && n < 500) begin @(posedge clk); #1; n++; end
    chk({tag, " finish seen"}, 128'(n < 500), 128'(1));
    if (!rdy_mode) chk({tag, " finish latency"}, 128'(wf_cyc - cap), 128'(exp_q.size()));
    repeat (3) @(posedge clk);
    #1;
    cmp_bytes(tag, base);
    chk({tag, " finish count"}, 128'(wf_cnt - wf0), 128'(1));
    chk({tag, " idle busy"}, 128'(busy), 128'(0));
  endtask

  function automatic logic [127:0] rand_path();
    logic [127:0] p, one;
    int l;
    one = 128'd1;
    p = {$urandom, $urandom, $urandom, $urandom};
    l = $urandom_range(1, 127);
    return (p & ((one << l) - one)) | (one << l);
  endfunction

  initial begin
    int base, wf0, n;
    logic [127:0] ones;
    ones = '1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst byte_out", 128'(byte_out), 128'(0));
    chk("rst byte_valid", 128'(byte_valid), 128'(0));
    chk("rst write_finish", 128'(write_finish), 128'(0));
    chk("rst header_done", 128'(header_done), 128'(0));
    chk("rst busy", 128'(busy), 128'(0));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send_entry("basic", 8'h41, 128'b1011);
    send_entry("nine", 8'h07, 128'b1100000001);
    send_entry("max", 8'hA5, ones);
    send_entry("degen1", 8'h11, 128'd1);
    send_entry("degen0", 8'h12, 128'd0);
    for (int k = 0; k < 6; k++) send_entry($sformatf("rand%0d", k), 8'($urandom), rand_path());

    rdy_mode = 1'b1;
    send_entry("bp basic", 8'h41, 128'b1011);
    send_entry("bp max", 8'h3C, ones);
    for (int k = 0; k < 4; k++) send_entry($sformatf("bp rand%0d", k), 8'($urandom), rand_path());
    chk("bp stability", 128'(stab_err), 128'(0));
    rdy_mode = 1'b0;
    @(posedge clk); #1;

    // Abort a long entry in the middle of its path bytes.
    wf0 = wf_cnt;
    char_index = 8'h99; char_path = ones; char_found = 1'b1;
    @(posedge clk); #1;
    char_found = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid busy", 128'(busy), 128'(1));
    rst = 1'b0;
    #1;
    chk("arst byte_out", 128'(byte_out), 128'(0));
    chk("arst byte_valid", 128'(byte_valid), 128'(0));
    chk("arst busy", 128'(busy), 128'(0));
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    chk("arst no finish", 128'(wf_cnt - wf0), 128'(0));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_entry("post rst", 8'h41, 128'b1011);

    // Finish raised mid-entry: entry completes, then terminator.
    base = got_q.size();
    wf0 = wf_cnt;
    build_exp(8'h55, 128'h1_2345);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    char_index = 8'h55; char_path = 128'h1_2345; char_found = 1'b1;
    @(posedge clk); #1;
    char_found = 1'b0;
    @(posedge clk); #1;
    cb_finished = 1'b1;
    @(posedge clk); #1;
    cb_finished = 1'b0;
    chk("term hd low mid", 128'(header_done), 128'(0));
    n = 0;
    while (!header_done && n < 500) begin @(posedge clk); #1; n++; end
    chk("term done seen", 128'(n < 500), 128'(1));
    cmp_bytes("term", base);
    chk("term finish count", 128'(wf_cnt - wf0), 128'(1));
    base = got_q.size();
    char_index = 8'h42; char_path = 128'b1011; char_found = 1'b1;
    @(posedge clk); #1;
    char_found = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("halt no bytes", 128'(got_q.size() - base), 128'(0));
    chk("halt hd held", 128'(header_done), 128'(1));
    chk("halt busy", 128'(busy), 128'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
